// File: rtl/systolic_row_feeder.sv
// rtl/systolic_row_feeder.sv - row sequencer and per-lane skew delay lines feeding a systolic array edge
module systolic_row_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 9,
  parameter int BLOCK_SIZE = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stall,
  output logic                             mem_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0]     mem_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] feed_data,
  output logic [BLOCK_SIZE-1:0]            feed_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int RW = $clog2(BLOCK_SIZE);
  localparam logic [RW-1:0] LAST_IDX = RW'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [RW-1:0]       r_row;
  logic [RW-1:0]       r_drain;
  logic                w_active;
  logic                w_shift;
  logic                w_fill;
  logic [BLOCK_SIZE-1:0] w_lane_vld;

  // The row counter is never advanced past the last row, so the address
  // naturally holds during DRAIN and is cleared only by reset or a new start.
  assign mem_addr = AW'(r_row) * AW'(BLOCK_SIZE);
  assign w_active = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_shift  = w_active && !stall;
  assign w_fill   = (r_state == S_FETCH);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; stall only matters while streaming
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: if (!stall && r_row == LAST_IDX) w_next = S_DRAIN;
      S_DRAIN: if (!stall && r_drain == LAST_IDX) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Row and drain counters, frozen by stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row   <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row   <= '0;
            r_drain <= '0;
          end
        end
        S_FETCH: if (!stall && r_row != LAST_IDX) r_row <= r_row + 1'b1;
        S_DRAIN: if (!stall && r_drain != LAST_IDX) r_drain <= r_drain + 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode; valids are masked while stalled so the array sees a bubble
  always_comb begin
    mem_rd_en  = (r_state == S_FETCH) && !stall;
    busy       = w_active;
    done       = (r_state == S_DONE);
    feed_valid = (w_active && stall) ? '0 : w_lane_vld;
  end

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_data [0:i];
    logic                  r_vld  [0:i];

    // Lane i is an (i+1)-deep shift register: memory word during FETCH, zero bubbles during DRAIN
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) begin
          r_data[k] <= '0;
          r_vld[k]  <= 1'b0;
        end
      end else if (w_shift) begin
        r_data[0] <= w_fill ? mem_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        r_vld[0]  <= w_fill;
        for (int k = 1; k <= i; k++) begin
          r_data[k] <= r_data[k-1];
          r_vld[k]  <= r_vld[k-1];
        end
      end
    end

    assign feed_data[i*DATA_WIDTH +: DATA_WIDTH] = r_data[i];
    assign w_lane_vld[i] = r_vld[i];
  end

endmodule

// File: tb/tb_systolic_row_feeder.sv
// tb/tb_systolic_row_feeder.sv - randomized self-checking bench for systolic_row_feeder at N=3 and N=4
module tb_systolic_row_feeder;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        start3, stall3, rd3, busy3, done3;
  logic [3:0]  addr3;
  logic [23:0] md3, fd3;
  logic [2:0]  fv3;

  logic        start4, stall4, rd4, busy4, done4;
  logic [3:0]  addr4;
  logic [31:0] md4, fd4;
  logic [3:0]  fv4;

  logic [7:0]  mem [2][16];

  systolic_row_feeder #(.DATA_WIDTH(8), .MEM_DEPTH(9), .BLOCK_SIZE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .stall(stall3),
    .mem_rd_en(rd3), .mem_addr(addr3), .mem_data(md3),
    .feed_data(fd3), .feed_valid(fv3), .busy(busy3), .done(done3)
  );

  systolic_row_feeder #(.DATA_WIDTH(8), .MEM_DEPTH(16), .BLOCK_SIZE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .stall(stall4),
    .mem_rd_en(rd4), .mem_addr(addr4), .mem_data(md4),
    .feed_data(fd4), .feed_valid(fv4), .busy(busy4), .done(done4)
  );

  always_comb begin
    md3 = '0;
    md4 = '0;
    for (int i = 0; i < 3; i++) md3[i*8 +: 8] = mem[0][(int'(addr3) + i) % 16];
    for (int i = 0; i < 4; i++) md4[i*8 +: 8] = mem[1][(int'(addr4) + i) % 16];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stream active flag and count of non-stalled cycles since start
  bit m_act [2];
  int m_c   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input int s);
    int n;
    int r;
    bit st;
    logic [31:0] efd, ofd;
    logic [3:0]  efv, ofv;
    bit ebusy, edone, erd;
    int eaddr;
    n = s ? 4 : 3;
    st = s ? stall4 : stall3;
    efd = '0; efv = '0; ebusy = 0; edone = 0; erd = 0; eaddr = 0;
    if (m_act[s] && m_c[s] < 2*n) begin
      ebusy = 1;
      erd   = (m_c[s] < n) && !st;
      eaddr = ((m_c[s] < n) ? m_c[s] : n - 1) * n;
      for (int i = 0; i < n; i++) begin
        r = m_c[s] - 1 - i;
        if (r >= 0 && r < n) begin
          efd[i*8 +: 8] = mem[s][r*n + i];
          efv[i] = !st;
        end
      end
    end else if (m_act[s]) begin
      edone = 1;
    end
    ofd = s ? fd4 : {8'h00, fd3};
    ofv = s ? fv4 : {1'b0, fv3};
    check(s ? "n4_busy" : "n3_busy", 32'(s ? busy4 : busy3), 32'(ebusy));
    check(s ? "n4_done" : "n3_done", 32'(s ? done4 : done3), 32'(edone));
    check(s ? "n4_rd_en" : "n3_rd_en", 32'(s ? rd4 : rd3), 32'(erd));
    if (erd) check(s ? "n4_addr" : "n3_addr", 32'(s ? addr4 : addr3), 32'(eaddr));
    check(s ? "n4_valid" : "n3_valid", 32'(ofv), 32'(efv));
    check(s ? "n4_data" : "n3_data", ofd, efd);
  endtask

  task automatic advance(input int s, input bit st, input bit sl);
    int n;
    n = s ? 4 : 3;
    if (!m_act[s]) begin
      if (st) begin
        m_act[s] = 1;
        m_c[s]   = 0;
      end
    end else if (m_c[s] == 2*n) begin
      m_act[s] = 0;
    end else if (!sl) begin
      m_c[s]++;
    end
  endtask

  task automatic step(input int s, input bit st, input bit sl);
    @(negedge clk);
    start3 = (s == 0) ? st : 1'b0;
    stall3 = (s == 0) ? sl : 1'b0;
    start4 = (s == 1) ? st : 1'b0;
    stall4 = (s == 1) ? sl : 1'b0;
    #1;
    check_inst(0);
    check_inst(1);
    advance(0, start3, stall3);
    advance(1, start4, stall4);
  endtask

  task automatic check_reset_outputs();
    check("rst_addr3", 32'(addr3), 32'd0);
    check("rst_addr4", 32'(addr4), 32'd0);
    check_inst(0);
    check_inst(1);
  endtask

  // kind: 0 basic, 1 stall at c=1, 2 start while busy and in DONE, 3 back-to-back, 4 random
  task automatic run_kind(input int s, input int kind);
    int n, len;
    bit st, sl;
    n = s ? 4 : 3;
    len = (kind == 4) ? 150 : 4*n + 6;
    for (int k = 0; k < len; k++) begin
      st = 0;
      sl = 0;
      case (kind)
        0: st = (k == 0);
        1: begin st = (k == 0); sl = (k == 2); end
        2: st = (k == 0 || k == 3 || k == 2*n + 1);
        3: st = (k == 0 || k == 2*n + 2);
        default: begin
          if (k < len - (2*n + 3)) begin
            st = ($urandom_range(0, 5) == 0);
            sl = ($urandom_range(0, 3) == 0);
          end
        end
      endcase
      step(s, st, sl);
    end
  endtask

  task automatic reset_mid(input int s);
    step(s, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(s, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    m_act[0] = 0;
    m_act[1] = 0;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    start3 = 0; stall3 = 0; start4 = 0; stall4 = 0;
    m_act[0] = 0; m_act[1] = 0; m_c[0] = 0; m_c[1] = 0;
    for (int j = 0; j < 16; j++) begin
      mem[0][j] = 8'(j + 1);
      mem[1][j] = 8'(8'h10 + j);
    end
    reset = 1'b1;
    #1;
    check_reset_outputs();
    #12;
    @(negedge clk);
    reset = 1'b0;

    for (int s = 0; s < 2; s++) begin
      for (int kind = 0; kind < 4; kind++) run_kind(s, kind);
      reset_mid(s);
      run_kind(s, 0);
    end

    for (int rep = 0; rep < 4; rep++) begin
      for (int s = 0; s < 2; s++) begin
        for (int j = 0; j < 16; j++) mem[s][j] = 8'($urandom);
        run_kind(s, 4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
